pc_irq_unit: RTL and testbench

Parametrised program-counter unit with vectored interrupt entry and return, for the multi-cycle/single-cycle CPU datapath. It replaces the plain clock-enabled PC register. It selects the next PC (sequential, branch, jump or hold), latches edge-triggered interrupt requests from NUM_IRQ channels, and redirects fetch to a per-channel vector while saving the return address in EPC. Interrupts do not nest; eret restores EPC.

---
 rtl/pc_irq_unit.sv | 131 +++++++++++++
 tb/tb_pc_irq_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_irq_unit.sv
// Program counter with next-PC select, edge-latched vectored interrupts,
// single-level interrupt entry/return and saved return address.
module pc_irq_unit #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_VEC  = '0,
    parameter int unsigned      INC        = 4,
    parameter int unsigned      NUM_IRQ    = 4,
    parameter logic [WIDTH-1:0] IRQ_BASE   = WIDTH'(32'h0000_0100),
    parameter logic [WIDTH-1:0] VEC_STRIDE = WIDTH'(32'h0000_0010),
    localparam int unsigned     CW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic [1:0]         pc_sel,
    input  logic [WIDTH-1:0]   branch_target,
    input  logic [WIDTH-1:0]   jump_target,
    input  logic               eret,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    output logic [WIDTH-1:0]   pc_out,
    output logic [WIDTH-1:0]   epc_out,
    output logic               in_service,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic [CW-1:0]      cause_id
);

    typedef enum logic {
        IDLE,
        SERVICE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pc_q, pc_d;
    logic [WIDTH-1:0]   epc_q, epc_d;
    logic [CW-1:0]      cause_q, cause_d;
    logic [NUM_IRQ-1:0] ack_q, ack_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] irq_q;

    logic [WIDTH-1:0]   npc;
    logic [WIDTH-1:0]   vec;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] sel_oh;
    logic [NUM_IRQ-1:0] irq_rise;
    logic [CW-1:0]      sel;
    logic               take;

    always_comb begin
        npc = pc_q;
        case (pc_sel)
            2'b00:   npc = pc_q + WIDTH'(INC);
            2'b01:   npc = branch_target;
            2'b10:   npc = jump_target;
            default: npc = pc_q;
        endcase
    end

    // Lowest eligible channel wins; sel_oh isolates its bit.
    always_comb begin
        eligible = pending_q & ~irq_mask;
        sel_oh   = eligible & (~eligible + NUM_IRQ'(1));
        sel      = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) sel = CW'(i);
        end
        vec      = IRQ_BASE + VEC_STRIDE * WIDTH'(sel);
        irq_rise = irq & ~irq_q;
        take     = ce && (state_q == IDLE) && (|eligible);
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        epc_d     = epc_q;
        cause_d   = cause_q;
        ack_d     = '0;
        pending_d = (pending_q & ~(take ? sel_oh : '0)) | irq_rise;
        if (ce) begin
            case (state_q)
                IDLE: begin
                    if (take) begin
                        pc_d    = vec;
                        epc_d   = npc;
                        cause_d = sel;
                        ack_d   = sel_oh;
                        state_d = SERVICE;
                    end else begin
                        pc_d = npc;
                    end
                end
                SERVICE: begin
                    if (eret) begin
                        pc_d    = epc_q;
                        state_d = IDLE;
                    end else begin
                        pc_d = npc;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_VEC;
            epc_q     <= '0;
            cause_q   <= '0;
            ack_q     <= '0;
            pending_q <= '0;
            irq_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
            ack_q     <= ack_d;
            pending_q <= pending_d;
            irq_q     <= irq;
        end
    end

    assign pc_out     = pc_q;
    assign epc_out    = epc_q;
    assign in_service = (state_q == SERVICE);
    assign irq_ack    = ack_q;
    assign cause_id   = cause_q;

endmodule

// File: tb/tb_pc_irq_unit.sv
// Directed bench for pc_irq_unit: expected state queued per step,
// popped and compared after each clock.
module tb_pc_irq_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [1:0]  pc_sel;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        eret;
    logic [3:0]  irq;
    logic [3:0]  irq_mask;
    logic [31:0] pc_out;
    logic [31:0] epc_out;
    logic        in_service;
    logic [3:0]  irq_ack;
    logic [1:0]  cause_id;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        svc;
        logic [3:0]  ack;
        logic [1:0]  cause;
    } exp_t;

    exp_t sb[$];

    pc_irq_unit dut (
        .clk          (clk),
        .rst          (rst),
        .ce           (ce),
        .pc_sel       (pc_sel),
        .branch_target(branch_target),
        .jump_target  (jump_target),
        .eret         (eret),
        .irq          (irq),
        .irq_mask     (irq_mask),
        .pc_out       (pc_out),
        .epc_out      (epc_out),
        .in_service   (in_service),
        .irq_ack      (irq_ack),
        .cause_id     (cause_id)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] pc,
                        input logic [31:0] epc, input logic svc,
                        input logic [3:0] ack, input logic [1:0] cause);
        exp_t e;
        e.tag = tag;
        e.pc = pc;
        e.epc = epc;
        e.svc = svc;
        e.ack = ack;
        e.cause = cause;
        sb.push_back(e);
    endtask

    task automatic compare_all();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            assert (pc_out === e.pc) else begin
                failures++;
                $error("FAIL %s pc: got %h expected %h", e.tag, pc_out, e.pc);
            end
            checks++;
            assert (epc_out === e.epc) else begin
                failures++;
                $error("FAIL %s epc: got %h expected %h", e.tag, epc_out, e.epc);
            end
            checks++;
            assert (in_service === e.svc) else begin
                failures++;
                $error("FAIL %s svc: got %b expected %b", e.tag, in_service, e.svc);
            end
            checks++;
            assert (irq_ack === e.ack) else begin
                failures++;
                $error("FAIL %s ack: got %b expected %b", e.tag, irq_ack, e.ack);
            end
            checks++;
            assert (cause_id === e.cause) else begin
                failures++;
                $error("FAIL %s cause: got %0d expected %0d", e.tag, cause_id, e.cause);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ce = 1'b0;
        pc_sel = 2'b00;
        branch_target = '0;
        jump_target = '0;
        eret = 1'b0;
        irq = '0;
        irq_mask = '0;
        #12;
        push("reset", 32'h0, 32'h0, 1'b0, 4'b0, 2'd0);
        compare_all();
        @(negedge clk);
        rst = 1'b0;

        ce = 1'b1;
        push("seq1", 32'h4, 32'h0, 1'b0, 4'b0, 2'd0); tick();
        push("seq2", 32'h8, 32'h0, 1'b0, 4'b0, 2'd0); tick();
        push("seq3", 32'hC, 32'h0, 1'b0, 4'b0, 2'd0); tick();
        ce = 1'b0;
        push("stall1", 32'hC, 32'h0, 1'b0, 4'b0, 2'd0); tick();
        push("stall2", 32'hC, 32'h0, 1'b0, 4'b0, 2'd0); tick();
        ce = 1'b1;
        pc_sel = 2'b11;
        push("hold", 32'hC, 32'h0, 1'b0, 4'b0, 2'd0); tick();
        pc_sel = 2'b00;
        push("seq4", 32'h10, 32'h0, 1'b0, 4'b0, 2'd0); tick();
        pc_sel = 2'b01;
        branch_target = 32'h40;
        push("branch", 32'h40, 32'h0, 1'b0, 4'b0, 2'd0); tick();
        pc_sel = 2'b10;
        jump_target = 32'h200;
        push("jump", 32'h200, 32'h0, 1'b0, 4'b0, 2'd0); tick();
        jump_target = 32'hFFFF_FFFC;
        push("jmp_top", 32'hFFFF_FFFC, 32'h0, 1'b0, 4'b0, 2'd0); tick();
        pc_sel = 2'b00;
        push("wrap", 32'h0, 32'h0, 1'b0, 4'b0, 2'd0); tick();

        pc_sel = 2'b10;
        jump_target = 32'h1C;
        push("jmp_1c", 32'h1C, 32'h0, 1'b0, 4'b0, 2'd0); tick();
        pc_sel = 2'b00;
        irq = 4'b0100;
        push("irq2_edge", 32'h20, 32'h0, 1'b0, 4'b0, 2'd0); tick();
        irq = 4'b0000;
        push("irq2_entry", 32'h120, 32'h24, 1'b1, 4'b0100, 2'd2); tick();
        push("ack_once", 32'h124, 32'h24, 1'b1, 4'b0, 2'd2); tick();
        eret = 1'b1;
        push("eret1", 32'h24, 32'h24, 1'b0, 4'b0, 2'd2); tick();
        push("eret_idle", 32'h28, 32'h24, 1'b0, 4'b0, 2'd2); tick();
        eret = 1'b0;

        irq_mask = 4'b0010;
        irq = 4'b1010;
        push("irq31_edge", 32'h2C, 32'h24, 1'b0, 4'b0, 2'd2); tick();
        irq = 4'b0000;
        push("irq3_entry", 32'h130, 32'h30, 1'b1, 4'b1000, 2'd3); tick();
        push("svc3_seq", 32'h134, 32'h30, 1'b1, 4'b0, 2'd3); tick();
        eret = 1'b1;
        irq_mask = 4'b0000;
        push("eret3", 32'h30, 32'h30, 1'b0, 4'b0, 2'd3); tick();
        eret = 1'b0;
        push("irq1_entry", 32'h110, 32'h34, 1'b1, 4'b0010, 2'd1); tick();

        irq = 4'b0001;
        push("nest_edge", 32'h114, 32'h34, 1'b1, 4'b0, 2'd1); tick();
        irq = 4'b0000;
        push("no_nest", 32'h118, 32'h34, 1'b1, 4'b0, 2'd1); tick();
        ce = 1'b0;
        push("svc_stall1", 32'h118, 32'h34, 1'b1, 4'b0, 2'd1); tick();
        push("svc_stall2", 32'h118, 32'h34, 1'b1, 4'b0, 2'd1); tick();
        ce = 1'b1;
        eret = 1'b1;
        push("eret1b", 32'h34, 32'h34, 1'b0, 4'b0, 2'd1); tick();
        eret = 1'b0;
        push("irq0_entry", 32'h100, 32'h38, 1'b1, 4'b0001, 2'd0); tick();

        irq = 4'b0010;
        push("irq1_pend", 32'h104, 32'h38, 1'b1, 4'b0, 2'd0); tick();
        irq = 4'b0000;
        rst = 1'b1;
        #1;
        push("rst_mid", 32'h0, 32'h0, 1'b0, 4'b0, 2'd0);
        compare_all();
        @(negedge clk);
        rst = 1'b0;
        push("post_rst1", 32'h4, 32'h0, 1'b0, 4'b0, 2'd0); tick();
        push("post_rst2", 32'h8, 32'h0, 1'b0, 4'b0, 2'd0); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
